// File: rtl/moonlanders_pkg.sv
// Shared constants for the moonlanders frame renderer: object IDs, box sizes,
// screen size and the renderer state encoding.
package moonlanders_pkg;

  localparam logic [7:0] ROCKET      = 8'd1;
  localparam logic [7:0] ASTEROID1   = 8'd2;
  localparam logic [7:0] ASTEROID2   = 8'd3;
  localparam logic [7:0] ASTEROID3   = 8'd4;
  localparam logic [7:0] ASTEROID4   = 8'd5;
  localparam logic [7:0] ASTEROID5   = 8'd6;
  localparam logic [7:0] ASTEROID6   = 8'd7;
  localparam logic [7:0] ASTEROID7   = 8'd8;
  localparam logic [7:0] ASTEROID8   = 8'd9;
  localparam logic [7:0] NUM_OBJECTS = 8'd9;

  localparam logic [7:0] ROCKET_W   = 8'd7;
  localparam logic [6:0] ROCKET_H   = 7'd15;
  localparam logic [7:0] ASTEROID_W = 8'd4;
  localparam logic [6:0] ASTEROID_H = 7'd4;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SELECT,
    S_LOAD,
    S_DRAW,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic logic [7:0] obj_width(input logic [7:0] id);
    return (id == ROCKET) ? ROCKET_W : ASTEROID_W;
  endfunction

  function automatic logic [6:0] obj_height(input logic [7:0] id);
    return (id == ROCKET) ? ROCKET_H : ASTEROID_H;
  endfunction

endpackage

// File: rtl/object_renderer_if.sv
// Object-select lookup plus VGA pixel write port; master is the renderer side.
interface object_renderer_if;
  logic [7:0] object;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output object, x, y, colour, plot, input iX, iY);
  modport slave  (input object, x, y, colour, plot, output iX, iY);
endinterface

// File: rtl/object_renderer_box_scanner.sv
// Walks a width x height box row-major (x fastest) from a base point and flags
// pixels that land inside the visible screen.
module box_scanner
  import moonlanders_pkg::*;
#(
  parameter int X_LIMIT = SCREEN_W,
  parameter int Y_LIMIT = SCREEN_H
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       in_bounds,
  output logic       last
);

  logic [7:0] bx_q, w_q, dx_q;
  logic [6:0] by_q, h_q, dy_q;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       dx_end, dy_end;

  assign dx_end = (dx_q == w_q - 8'd1);
  assign dy_end = (dy_q == h_q - 7'd1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bx_q <= '0;
      by_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else if (load) begin
      bx_q <= base_x;
      by_q <= base_y;
      w_q  <= width;
      h_q  <= height;
      dx_q <= '0;
      dy_q <= '0;
    end else if (enable) begin
      if (dx_end) begin
        dx_q <= '0;
        dy_q <= dy_end ? 7'd0 : dy_q + 7'd1;
      end else begin
        dx_q <= dx_q + 8'd1;
      end
    end
  end

  // Sums are one bit wider than the port so off-screen pixels never wrap back in
  assign sum_x     = {1'b0, bx_q} + {1'b0, dx_q};
  assign sum_y     = {1'b0, by_q} + {1'b0, dy_q};
  assign pix_x     = sum_x[7:0];
  assign pix_y     = sum_y[6:0];
  assign in_bounds = (sum_x < 9'(X_LIMIT)) && (sum_y < 8'(Y_LIMIT));
  assign last      = dx_end && dy_end;

endmodule

// File: rtl/object_renderer.sv
// Frame sequencer: selects objects 1..9, reads their positions and rasterises
// each box to the VGA port. OBJECT_RENDERER_CLEAR_EN adds a full-screen clear.
//
// state    | meaning
// IDLE     | waiting for start, object 0
// CLEAR    | painting the whole screen with BG_COLOUR
// SELECT   | object presented to the position source
// LOAD     | position and box size captured into the scanner
// DRAW     | one box pixel per cycle
// NEXT     | advance to the next object or finish
// FINISH   | done pulse, object back to 0
module object_renderer
  import moonlanders_pkg::*;
#(
  parameter int         X_SCREEN_PIXELS = 160,
  parameter int         Y_SCREEN_PIXELS = 120,
  parameter logic [2:0] ROCKET_COLOUR   = 3'b111,
  parameter logic [2:0] ASTEROID_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR       = 3'b000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  object_renderer_if.master   bus
);

  state_t     state_q, next_state;
  logic [7:0] object_q, next_object;
  logic       sc_load, sc_enable;
  logic [7:0] ld_x, ld_w;
  logic [6:0] ld_y, ld_h;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       in_bounds, sc_last;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q, pix_colour;
  logic       plot_q;

  box_scanner #(
    .X_LIMIT (X_SCREEN_PIXELS),
    .Y_LIMIT (Y_SCREEN_PIXELS)
  ) u_scanner (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (sc_load),
    .enable    (sc_enable),
    .base_x    (ld_x),
    .base_y    (ld_y),
    .width     (ld_w),
    .height    (ld_h),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .in_bounds (in_bounds),
    .last      (sc_last)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      object_q <= '0;
    end else begin
      state_q  <= next_state;
      object_q <= next_object;
    end
  end

  always_comb begin
    next_state  = state_q;
    next_object = object_q;
    sc_load     = 1'b0;
    sc_enable   = 1'b0;
    ld_x        = bus.iX;
    ld_y        = bus.iY;
    ld_w        = obj_width(object_q);
    ld_h        = obj_height(object_q);
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef OBJECT_RENDERER_CLEAR_EN
          next_state = S_CLEAR;
          sc_load    = 1'b1;
          ld_x       = '0;
          ld_y       = '0;
          ld_w       = 8'(X_SCREEN_PIXELS);
          ld_h       = 7'(Y_SCREEN_PIXELS);
`else
          next_state  = S_SELECT;
          next_object = ROCKET;
`endif
        end
      end
`ifdef OBJECT_RENDERER_CLEAR_EN
      S_CLEAR: begin
        sc_enable = 1'b1;
        if (sc_last) begin
          next_state  = S_SELECT;
          next_object = ROCKET;
        end
      end
`endif
      S_SELECT: next_state = S_LOAD;
      S_LOAD: begin
        sc_load    = 1'b1;
        next_state = S_DRAW;
      end
      S_DRAW: begin
        sc_enable = 1'b1;
        if (sc_last) next_state = S_NEXT;
      end
      S_NEXT: begin
        if (object_q == NUM_OBJECTS) begin
          next_state = S_FINISH;
        end else begin
          next_state  = S_SELECT;
          next_object = object_q + 8'd1;
        end
      end
      S_FINISH: begin
        done        = 1'b1;
        next_object = '0;
        next_state  = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Only DRAW can be outside the screen; the clear box is the screen itself
  assign pix_colour = (state_q != S_DRAW) ? BG_COLOUR :
                      (object_q == ROCKET) ? ROCKET_COLOUR : ASTEROID_COLOUR;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= sc_enable && in_bounds;
      if (sc_enable) begin
        x_q      <= pix_x;
        y_q      <= pix_y;
        colour_q <= pix_colour;
      end
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign bus.object = object_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;

endmodule

// File: tb/tb_object_renderer.sv
// Directed bench for object_renderer with a pixel scoreboard.
module tb_object_renderer;
  import moonlanders_pkg::*;

`ifdef OBJECT_RENDERER_CLEAR_EN
  localparam bit CLR_ON    = 1'b1;
  localparam int FRAME_LEN = 19460;
`else
  localparam bit CLR_ON    = 1'b0;
  localparam int FRAME_LEN = 260;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  object_renderer_if bus ();

  object_renderer dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  logic [7:0] pos_x [0:9];
  logic [6:0] pos_y [0:9];

  assign bus.iX = (bus.object >= 8'd1 && bus.object <= 8'd9) ? pos_x[bus.object[3:0]] : 8'd0;
  assign bus.iY = (bus.object >= 8'd1 && bus.object <= 8'd9) ? pos_y[bus.object[3:0]] : 7'd0;

  pix_t       exp_q [$];
  logic [7:0] obj_seq [$];
  logic [7:0] last_obj;
  pix_t       e;
  int         passed = 0;
  int         total = 0;
  int         busy_total = 0;
  int         done_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic push_frame();
    int w, h, px, py;
    if (CLR_ON)
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++)
          exp_q.push_back(pix_t'{x: 8'(xx), y: 7'(yy), c: 3'b000});
    for (int o = 1; o <= 9; o++) begin
      w = (o == 1) ? 7 : 4;
      h = (o == 1) ? 15 : 4;
      for (int dy = 0; dy < h; dy++)
        for (int dx = 0; dx < w; dx++) begin
          px = int'(pos_x[o]) + dx;
          py = int'(pos_y[o]) + dy;
          if (px < 160 && py < 120)
            exp_q.push_back(pix_t'{x: 8'(px), y: 7'(py), c: (o == 1) ? 3'b111 : 3'b100});
        end
    end
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int restart_at);
    int b0, d0, n;
    b0 = busy_total;
    d0 = done_total;
    obj_seq.delete();
    last_obj = 8'd0;
    push_frame();
    pulse_start();
    n = 0;
    while (done_total == d0 && n < 30000) begin
      @(negedge Clock);
      #1;
      start = (n == restart_at) ? 1'b1 : 1'b0;
      n++;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      #1;
    end
    check({tag, "_done_count"}, done_total - d0, 1);
    check({tag, "_frame_len"}, busy_total - b0, FRAME_LEN);
    check({tag, "_idle_after"}, {31'd0, busy}, 0);
    check({tag, "_missing_pixels"}, exp_q.size(), 0);
    check({tag, "_obj_seq_len"}, obj_seq.size(), 10);
    for (int i = 0; i < obj_seq.size() && i < 10; i++)
      check({tag, "_obj_seq"}, obj_seq[i], (i == 9) ? 0 : i + 1);
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 10; i++) begin
      pos_x[i] = 8'd0;
      pos_y[i] = 7'd0;
    end
    last_obj = 8'd0;

    fork
      forever begin
        @(negedge Clock);
        if (Reset) begin
          if (busy) busy_total++;
          if (done) done_total++;
          if (bus.object !== last_obj) begin
            obj_seq.push_back(bus.object);
            last_obj = bus.object;
          end
          if (bus.plot === 1'b1) begin
            check("plot_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("pix_x", bus.x, e.x);
              check("pix_y", bus.y, e.y);
              check("pix_colour", bus.colour, e.c);
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge Clock);
    #1;
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_colour", bus.colour, 0);
    check("rst_plot", bus.plot, 0);
    check("rst_object", bus.object, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge Clock);
    Reset = 1'b1;

    // Basic frame
    pos_x[1] = 8'd10;
    pos_y[1] = 7'd20;
    for (int i = 2; i <= 9; i++) begin
      pos_x[i] = 8'(50 + 10 * (i - 2));
      pos_y[i] = 7'd5;
    end
    run_frame("basic", -1);

    // Edge clipping of the rocket
    pos_x[1] = 8'd157;
    pos_y[1] = 7'd110;
    run_frame("clip", -1);

    // Start while busy is ignored
    pos_x[1] = 8'd30;
    pos_y[1] = 7'd40;
    pos_x[5] = 8'd158;
    pos_y[5] = 7'd118;
    run_frame("restart", 100);

    // Reset in the middle of asteroid 3
    push_frame();
    pulse_start();
    n = 0;
    while (bus.object !== 8'd4 && n < 30000) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check("reach_ast3", bus.object, 4);
    repeat (5) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("midrst_plot", bus.plot, 0);
    check("midrst_object", bus.object, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    @(negedge Clock);
    Reset = 1'b1;
    run_frame("after_rst", -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/object_renderer.md
# object_renderer

Frame-drawing sequencer on the consumer side of the collision block's object-select interface. On each frame trigger it drives `object` from 1 to 9 and samples the returned `iX`/`iY`. It then rasterises each object's box (rocket 7×15, asteroids 4×4) one pixel per cycle into the VGA adapter's `x`/`y`/`colour`/`plot` write port. It sits between the collision/position logic and the VGA adapter.

## Interface
- `X_SCREEN_PIXELS`, default 160: visible width; pixels at or beyond it are clipped.
- `Y_SCREEN_PIXELS`, default 120: visible height; pixels at or beyond it are clipped.
- `ROCKET_COLOUR`, default 3'b111: colour for object 1.
- `ASTEROID_COLOUR`, default 3'b100: colour for objects 2–9.
- `BG_COLOUR`, default 3'b000: background colour, used only by screen clear.

Ports:
- `Clock` in 1: single system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame trigger.
- `object` out 8: object select to the position source (1 = rocket, 2–9 = asteroid1–8, 0 = none).
- `iX` in 8: selected object's X. Combinational from `object`, valid in the same cycle.
- `iY` in 7: selected object's Y. Combinational from `object`, valid in the same cycle.
- `x` out 8: pixel X to the VGA adapter.
- `y` out 7: pixel Y to the VGA adapter.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write strobe.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, CLEAR, SELECT, LOAD, DRAW, NEXT, FINISH.
- IDLE:
  - `object`=0, `plot`=0.
  - `start`=1 → CLEAR if the clear feature is compiled in, else → SELECT with object=1.
- CLEAR:
  - Raster the full screen in row-major order, x fastest, with `colour`=BG_COLOUR and `plot`=1.
  - After (159,119) → SELECT with object=1.
- SELECT: `object` is registered and stable. One cycle, then → LOAD.
- LOAD:
  - Capture `iX`/`iY` into base registers.
  - Load width/height from the object ID: 7×15 for ID 1, 4×4 for IDs 2–9.
  - Clear dx/dy → DRAW.
- DRAW:
  - Each cycle: `x`=baseX+dx and `y`=baseY+dy, computed 9/8 bits wide with no wrap.
  - `plot`=1 unless the sum is ≥ X_SCREEN_PIXELS or ≥ Y_SCREEN_PIXELS. A clipped pixel still advances the counters.
  - dx increments; at width−1, dx returns to 0 and dy increments. At (width−1, height−1) → NEXT.
- NEXT: object=9 → FINISH; else object+1 → SELECT.
- FINISH: `done`=1 for one cycle, object=0 → IDLE.
- `start` while `busy` is ignored; it is not queued.
- Objects are drawn in fixed order 1..9. Later objects overwrite earlier ones where they overlap.

## Timing
- Reset values: state=IDLE, `object`=0, `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0, and all counters 0.
- `x`/`y`/`colour`/`plot` are registered: one cycle after the pixel's DRAW or CLEAR cycle.
- Per object: 2 overhead cycles (SELECT, LOAD), then W×H DRAW cycles, then 1 NEXT cycle.
- Draw cycles per frame: rocket 105, asteroids 8×16 = 128.
- Frame with clear off: 9×3 + 233 = 260 cycles from the `start` cycle to the `done` pulse.
- Frame with clear on: add 19200 CLEAR cycles.
- Reset asserted mid-frame: immediate return to reset values, with no partial `done`.

## Configuration
- `OBJECT_RENDERER_CLEAR_EN` defined: CLEAR state present; every frame begins by painting the whole screen with BG_COLOUR.
- Not defined: CLEAR state and its counters are not built; IDLE goes directly to SELECT, and stale pixels remain on screen.

## Structure
- Shared package, `moonlanders_pkg`:
  - Object ID constants: ROCKET=1, ASTEROID1..8=2..9, NUM_OBJECTS=9.
  - Rocket width/height (7, 15) and asteroid width/height (4, 4).
  - Screen dimensions.
  - State enum.
- One sub-module, `box_scanner`:
  - Inputs: load, base X/Y, width, height, enable.
  - Outputs: pixel X/Y, in-bounds flag, last-pixel flag.
  - Reused for CLEAR as a box at (0,0) of size 160×120.

## Test plan
- **Basic frame.** Reset, clear off, rocket at (10,20), asteroids at (50,5)…(120,5); pulse `start`.
  - 233 plot pixels: rocket covers x 10–16, y 20–34 in white; each asteroid is a 4×4 red box.
  - `done` arrives 260 cycles after `start`.
- **Edge clipping.** Rocket at (157,110).
  - Only x 157–159, y 110–119 are plotted (30 pixels).
  - Total frame length is unchanged.
- **Object sequencing.** `object` steps 1→9 with each value held through SELECT/LOAD/DRAW, then returns to 0 after FINISH.
- **Start while busy.** `start` pulses again mid-frame → exactly one `done`, and frame length is unchanged.
- **Reset mid-DRAW.** Assert `Reset` during asteroid 3.
  - Next cycle: `plot`=0, `object`=0, `busy`=0.
  - A following `start` runs a full, clean frame.
- **Screen clear.** `OBJECT_RENDERER_CLEAR_EN` defined.
  - First 19200 plotted pixels are BG_COLOUR, covering (0,0)…(159,119) in order.
  - `done` at 19460 cycles.
